// File: rtl/booth_radix4_digit_decoder_pkg.sv
// ============================================================================
//  Module  : booth_pkg
//  Brief   : Shared Booth digit types, magnitude codes and decoder FSM states.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package booth_pkg;

    typedef struct packed {
        logic       sign;
        logic [1:0] b;
    } booth_digit_t;

    typedef enum logic [1:0] {
        BOOTH_ZERO = 2'b00,
        BOOTH_ONE  = 2'b01,
        BOOTH_TWO  = 2'b10
    } booth_mag_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } dec_state_t;

    // Codes an encoder never emits: magnitude 3, or a negative zero.
    function automatic logic booth_digit_illegal(booth_digit_t d);
        return (d.b == 2'b11) || (d.sign && (d.b == 2'b00));
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_radix4_digit_decoder_if.sv
// ============================================================================
//  Module  : booth_radix4_digit_decoder_if
//  Brief   : Digit-in / product-out valid-ready bundle for the Booth decoder.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface booth_radix4_digit_decoder_if #(
    parameter int WIDTH = 8
) ();
    localparam int PW = 2 * WIDTH;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] mcand;
    logic [1:0]       dig_b;
    logic             dig_sign;
    logic             out_valid;
    logic             out_ready;
    logic [PW-1:0]    product;
    logic             err;

    modport master (
        output in_valid, mcand, dig_b, dig_sign, out_ready,
        input  in_ready, out_valid, product, err
    );

    modport slave (
        input  in_valid, mcand, dig_b, dig_sign, out_ready,
        output in_ready, out_valid, product, err
    );
endinterface

`default_nettype wire

// File: rtl/booth_radix4_digit_decoder_pp_gen.sv
// ============================================================================
//  Module  : booth_pp_gen
//  Brief   : Combinational Booth digit + multiplicand -> sign-extended PW-bit
//            partial product (0, +/-M, +/-2M).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PW    = 2 * WIDTH
) (
    input  wire logic [WIDTH-1:0] i_mcand,
    input  wire booth_digit_t     i_digit,
    output logic [PW-1:0]         o_pp
);

    logic [WIDTH:0] w_mag;
    logic [PW-1:0]  w_mag_ext;

    // One extra bit keeps 2*(-2^(WIDTH-1)) exact.
    always_comb begin
        w_mag = '0;
        case (i_digit.b)
            BOOTH_ONE: w_mag = {i_mcand[WIDTH-1], i_mcand};
            BOOTH_TWO: w_mag = {i_mcand, 1'b0};
            default:   w_mag = '0;
        endcase
    end

    // Negate only after widening: -(-2^WIDTH) does not fit in WIDTH+1 bits.
    assign w_mag_ext = {{(PW-WIDTH-1){w_mag[WIDTH]}}, w_mag};
    assign o_pp      = i_digit.sign ? (PW'(0) - w_mag_ext) : w_mag_ext;

endmodule

`default_nettype wire

// File: rtl/booth_radix4_digit_decoder.sv
// ============================================================================
//  Module  : booth_radix4_digit_decoder
//  Brief   : Serial radix-4 Booth digit decoder/accumulator, LSB digit first,
//            emitting the exact signed product M*Y. Optional sticky illegal-
//            digit flag enabled by macro BOOTH_DIGIT_CHECK_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module booth_radix4_digit_decoder
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    booth_radix4_digit_decoder_if.slave bus
);

    localparam int NDIG = WIDTH / 2;
    localparam int PW   = 2 * WIDTH;
    localparam int CW   = $clog2(NDIG) + 1;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ACCUM = ACCUM;
    localparam logic [1:0] S_DONE  = DONE;

    localparam logic [CW-1:0] C_LAST = CW'(NDIG - 1);

    logic [1:0]       r_state;
    logic [PW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_m;

    logic             w_in_ready;
    logic             w_beat;
    logic [WIDTH-1:0] w_m_sel;
    logic [PW-1:0]    w_pp;
    booth_digit_t     w_digit;

    assign w_in_ready = (r_state != S_DONE);
    assign w_beat     = bus.in_valid & w_in_ready;
    assign w_digit    = '{sign: bus.dig_sign, b: bus.dig_b};
    // The first beat decodes against the live multiplicand; later beats use the captured copy.
    assign w_m_sel    = (r_state == S_IDLE) ? bus.mcand : r_m;

    booth_pp_gen #(
        .WIDTH (WIDTH),
        .PW    (PW)
    ) u_pp_gen (
        .i_mcand (w_m_sel),
        .i_digit (w_digit),
        .o_pp    (w_pp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_m     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_beat) begin
                        r_m     <= bus.mcand;
                        r_acc   <= w_pp;
                        r_cnt   <= CW'(1);
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_beat) begin
                        r_acc <= r_acc + (w_pp << {r_cnt, 1'b0});
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == C_LAST) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef BOOTH_DIGIT_CHECK_EN
    logic r_err;

    // First beat restarts the flag, so nothing leaks across operations.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == S_DONE) begin
            if (bus.out_ready) begin
                r_err <= 1'b0;
            end
        end else if (w_beat) begin
            r_err <= booth_digit_illegal(w_digit) | ((r_state == S_ACCUM) & r_err);
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.product   = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_booth_radix4_digit_decoder.sv
// ============================================================================
//  Module  : tb_booth_radix4_digit_decoder
//  Brief   : Self-checking bench for the serial Booth digit decoder.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_booth_radix4_digit_decoder;
    localparam int WIDTH = 8;

    typedef struct {
        logic [15:0] p;
        logic        e;
    } exp_t;

    typedef struct {
        logic [7:0]  m;
        logic [11:0] digs;
        logic [15:0] p;
        logic        ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    booth_radix4_digit_decoder_if #(.WIDTH(WIDTH)) bus ();

    booth_radix4_digit_decoder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic exp_err(input logic ill);
`ifdef BOOTH_DIGIT_CHECK_EN
        return ill;
`else
        return 1'b0 & ill;
`endif
    endfunction

    // Product scoreboard: compare whenever a product handshake is about to occur.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_product: got %h, expected none", bus.product);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", bus.product, e.p);
                check("err", {15'd0, bus.err}, {15'd0, e.e});
            end
        end
    end

    task automatic drive_beat(input logic [7:0] m, input logic [2:0] d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.mcand    = m;
        bus.dig_sign = d[2];
        bus.dig_b    = d[1:0];
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: got 0, expected 1 within 50 cycles");
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [7:0] m, input logic [11:0] digs, input int max_gap,
                          input bit scramble, input logic [15:0] p, input logic ill);
        logic [2:0] d;
        logic [7:0] mv;
        sb.push_back('{p: p, e: exp_err(ill)});
        for (int i = 0; i < 4; i++) begin
            if (i > 0 && max_gap > 0) begin
                repeat ($urandom_range(1, max_gap)) begin
                    bus.mcand = 8'($urandom);
                    @(posedge clk); #1;
                end
            end
            d  = digs[3*i +: 3];
            mv = (scramble && i > 0) ? 8'($urandom) : m;
            drive_beat(mv, d);
        end
        check("latency_out_valid", {15'd0, bus.out_valid}, 16'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
        #1;
    endtask

    localparam logic [11:0] T1 = {3'b000, 3'b000, 3'b101, 3'b001};

    vec_t vecs[8];

    initial begin
        vecs[0] = '{m: 8'd7,    digs: T1,                                     p: 16'hFFEB, ill: 1'b0};
        vecs[1] = '{m: 8'h80,   digs: {3'b110, 3'b000, 3'b000, 3'b000},       p: 16'h4000, ill: 1'b0};
        vecs[2] = '{m: 8'd3,    digs: {3'b000, 3'b000, 3'b001, 3'b001},       p: 16'h000F, ill: 1'b0};
        vecs[3] = '{m: 8'd127,  digs: {3'b010, 3'b010, 3'b010, 3'b010},       p: 16'h5456, ill: 1'b0};
        vecs[4] = '{m: 8'h80,   digs: {3'b101, 3'b101, 3'b101, 3'b101},       p: 16'h2A80, ill: 1'b0};
        vecs[5] = '{m: 8'hFF,   digs: {3'b000, 3'b000, 3'b000, 3'b001},       p: 16'hFFFF, ill: 1'b0};
        vecs[6] = '{m: 8'd7,    digs: {3'b000, 3'b100, 3'b101, 3'b001},       p: 16'hFFEB, ill: 1'b1};
        vecs[7] = '{m: 8'd5,    digs: {3'b000, 3'b000, 3'b001, 3'b011},       p: 16'h0014, ill: 1'b1};

        bus.in_valid  = 1'b0;
        bus.mcand     = '0;
        bus.dig_b     = '0;
        bus.dig_sign  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_in_ready",  {15'd0, bus.in_ready},  16'd1);
        check("reset_out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("reset_product",   bus.product,            16'h0000);
        check("reset_err",       {15'd0, bus.err},       16'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].m, vecs[i].digs, 0, 1'b0, vecs[i].p, vecs[i].ill);
            drain();
        end
        // Clean operation right after an illegal one must not carry err.
        run_op(8'd3, {3'b000, 3'b000, 3'b001, 3'b001}, 0, 1'b0, 16'h000F, 1'b0);
        drain();

        // Backpressure: product held, no digits accepted.
        bus.out_ready = 1'b0;
        run_op(8'd7, T1, 0, 1'b0, 16'hFFEB, 1'b0);
        bus.in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", {15'd0, bus.out_valid}, 16'd1);
            check("bp_in_ready",  {15'd0, bus.in_ready},  16'd0);
            check("bp_product",   bus.product,            16'hFFEB);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        check("post_hs_in_ready", {15'd0, bus.in_ready}, 16'd1);
        run_op(8'h80, {3'b110, 3'b000, 3'b000, 3'b000}, 0, 1'b0, 16'h4000, 1'b0);
        drain();

        // Reset in the middle of an operation discards it.
        drive_beat(8'd7, 3'b001);
        drive_beat(8'd7, 3'b101);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready",  {15'd0, bus.in_ready},  16'd1);
        check("midrst_out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("midrst_product",   bus.product,            16'h0000);
        run_op(8'd3, {3'b000, 3'b000, 3'b001, 3'b001}, 0, 1'b0, 16'h000F, 1'b0);
        drain();

        // Bubbles between beats and multiplicand changes after the first beat.
        for (int k = 0; k < 3; k++) begin
            run_op(8'd7, T1, 3, 1'b1, 16'hFFEB, 1'b0);
            drain();
        end

        // Random legal digit streams against an arithmetic model.
        for (int k = 0; k < 10; k++) begin
            logic [7:0]  m;
            logic [11:0] digs;
            logic [31:0] prod;
            int          y;
            int          dv;
            m = 8'($urandom);
            y = 0;
            for (int i = 0; i < 4; i++) begin
                dv = int'($urandom_range(0, 4)) - 2;
                digs[3*i +: 3] = {dv < 0, 2'(dv < 0 ? -dv : dv)};
                y = y + dv * (4 ** i);
            end
            prod = 32'($signed(m) * y);
            run_op(m, digs, k % 3, 1'b0, prod[15:0], 1'b0);
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
